timer_multi: RTL and testbench
==============================

# timer_multi

Parametrised multi-channel general-purpose timer for the SoC timer subsystem. It extends the single-channel prescaled up/down counter with configurable width, NCH compare channels, a center-aligned (up-down) mode and a shadowed auto-reload value. It also adds sticky interrupt flags and optional per-channel PWM outputs. Register-interface logic drives its inputs; `irq` feeds the interrupt controller.

## Interface
- `WIDTH`, 32, counter, load and compare width (≥2)
- `PSC_WIDTH`, 16, prescaler width
- `NCH`, 4, number of compare channels (1–8)

Ports:
- `clk`  in  1  sole clock; all logic on posedge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  count enable; prescaler and counter freeze when low
- `restart`  in  1  one-cycle re-arm pulse
- `prescaler`  in  PSC_WIDTH  a counter step occurs every prescaler+1 enabled cycles
- `load`  in  WIDTH  auto-reload (period) value
- `mode`  in  2  00 up, 01 down, 10 center, 11 treated as up
- `one_shot`  in  1  stop after the first update event
- `cmp`  in  NCH*WIDTH  compare values; channel i at [i*WIDTH +: WIDTH]
- `irq_clr`  in  NCH+1  write-1-to-clear for `irq`
- `count`  out  WIDTH  current count
- `dir`  out  1  0 counting up, 1 counting down
- `running`  out  1  counter active
- `tick`  out  1  update-event pulse
- `match`  out  NCH  compare-match pulses
- `irq`  out  NCH+1  sticky flags; bit 0 update, bit i+1 match of channel i
- `pwm`  out  NCH  PWM outputs (see Configuration)

## Operation
- Reset values: psc_cnt=0, load_sh=0, `count`=0, `dir`=0, `running`=1, and `tick`/`match`/`irq`/`pwm` all 0.
- Priority per cycle: `rst` > `restart` > stepping.
- `restart` sets psc_cnt=0 and load_sh=`load`. It sets `count` to `load` in down mode and to 0 otherwise. It sets `dir` to 1 in down mode and to 0 otherwise. It sets `running`=1, and acts regardless of `en`. `irq` is untouched.
- Step condition: `en` && `running` && psc_cnt==`prescaler`. psc_cnt then returns to 0. Otherwise, while `en` && `running`, psc_cnt increments.
- Up mode: on a step, count≠load_sh gives count+1. count==load_sh gives count←0 plus an update event.
- Down mode: on a step, count≠0 gives count−1. count==0 gives count←load_sh plus an update event.
- Center mode:
  - Counting up, `dir` flips to 1 at count==load_sh.
  - Counting down, `dir` flips to 0 at count==0, and that step is the update event (count stays 0).
  - Sequence for load_sh=3: 0,1,2,3,2,1,0(update),1…
  - With load_sh=0, count stays 0 and every step is an update event.
- Update event: load_sh←`load` (new value takes effect only at period boundaries) and `irq[0]` is set. If `one_shot` is set, `running`←0 after the reload value is written.
- Compare: channel i has an event when a step writes a count value equal to cmp[i]. This includes the reload value, and in center mode both the up and the down crossing.
- `irq` bit: set on its event, cleared by `irq_clr`; a set in the same cycle as a clear wins.
- Arithmetic is modulo 2^WIDTH. No wrap occurs outside the reload rules because load_sh bounds the count.

## Timing
- `count`, `dir`, `tick`, `match` and `pwm` are registered at the step edge: `tick`/`match` are high for exactly the one cycle in which the new `count` is visible.
- `irq` sets one cycle after the event edge, i.e. it is visible together with `tick`/`match` + 1.
- With prescaler=P, consecutive steps are P+1 cycles apart. An up-mode period is (load+1)(P+1) cycles and a center-mode period is 2·load·(P+1) cycles.
- A change to `prescaler` is compared live. If it drops below psc_cnt, psc_cnt runs to 2^PSC_WIDTH−1 and then wraps to 0.
- `restart` takes effect on the next edge, and the first step follows P+1 enabled cycles later.

## Configuration
- `TIMER_PWM_EN` defined: pwm[i] is registered at each step as (new count < cmp[i]). It is held between steps and forced to 0 by `rst`/`restart`.
- `TIMER_PWM_EN` not defined: `pwm` is tied to 0 and no comparator logic is built for it. `match`/`irq` are unaffected.

## Test plan
- Up, P=0, load=4, cmp0=2: `count` runs 0,1,2,3,4,0. `tick` is high with the 0 after 4, every 5 cycles. `match[0]` is high with count=2. With the macro, `pwm[0]` is high for counts 0–1.
- Down, P=2, one_shot=1, load=3, restart: `count` 3,2,1,0 with steps every 3 cycles. The next step reloads 3 and pulses `tick`, then `running`=0 and `count` holds at 3.
- Center, load=3, cmp1=2: `count` 0,1,2,3,2,1,0. `match[1]` pulses twice per period; `tick` pulses only at 0; `dir` is 1 during 2,1,0.
- Change `load` 4→2 at count=1 in up mode: the current period still reaches 4. The next period is 0,1,2.
- `irq_clr[0]`=1 in the same cycle a new update event sets `irq[0]`: `irq[0]` stays 1. A clear alone in the next cycle drops it to 0.
- Assert `rst` mid-count (count=7, psc_cnt=5): on the next edge all outputs are at reset values; with `en`=1 counting restarts from 0.

Source files
------------

// File: rtl/timer_multi.sv
// Multi-channel prescaled timer: up / down / center-aligned counting, shadowed reload,
// per-channel compare with sticky irq flags. Define TIMER_PWM_EN to build the PWM outputs.
module timer_multi #(
   parameter int WIDTH     = 32,
   parameter int PSC_WIDTH = 16,
   parameter int NCH       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   restart,
   input  logic [PSC_WIDTH-1:0]   prescaler,
   input  logic [WIDTH-1:0]       load,
   input  logic [1:0]             mode,
   input  logic                   one_shot,
   input  logic [NCH*WIDTH-1:0]   cmp,
   input  logic [NCH:0]           irq_clr,
   output logic [WIDTH-1:0]       count,
   output logic                   dir,
   output logic                   running,
   output logic                   tick,
   output logic [NCH-1:0]         match,
   output logic [NCH:0]           irq,
   output logic [NCH-1:0]         pwm
);

   typedef enum logic [1:0] {
      MODE_UP     = 2'b00,
      MODE_DOWN   = 2'b01,
      MODE_CENTER = 2'b10,
      MODE_UP_ALT = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0]     CNT_ONE = WIDTH'(1);
   localparam logic [PSC_WIDTH-1:0] PSC_ONE = PSC_WIDTH'(1);

   logic [PSC_WIDTH-1:0] r_psc_cnt;
   logic [WIDTH-1:0]     r_load_sh;
   logic [WIDTH-1:0]     r_count;
   logic                 r_dir;
   logic                 r_running;
   logic                 r_tick;
   logic [NCH-1:0]       r_match;
   logic [NCH:0]         r_irq;

   mode_e                w_mode;
   logic                 w_step;
   logic [WIDTH-1:0]     w_count_nxt;
   logic                 w_dir_nxt;
   logic                 w_update;
   logic [NCH-1:0]       w_match_nxt;

   assign w_mode = mode_e'(mode);
   assign w_step = en && r_running && (r_psc_cnt == prescaler);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_count_nxt = r_count;
      w_dir_nxt   = r_dir;
      w_update    = 1'b0;
      case (w_mode)
         MODE_DOWN: begin
            w_dir_nxt = 1'b1;
            if (r_count == '0) begin
               w_count_nxt = r_load_sh;
               w_update    = 1'b1;
            end else begin
               w_count_nxt = r_count - CNT_ONE;
            end
         end
         MODE_CENTER: begin
            // Turn around when leaving a boundary; the update is the step that lands on 0.
            if (r_load_sh == '0) begin
               w_count_nxt = '0;
               w_dir_nxt   = 1'b0;
               w_update    = 1'b1;
            end else if (!r_dir) begin
               if (r_count == r_load_sh) begin
                  w_dir_nxt   = 1'b1;
                  w_count_nxt = r_count - CNT_ONE;
               end else begin
                  w_count_nxt = r_count + CNT_ONE;
               end
            end else if (r_count == '0) begin
               w_dir_nxt   = 1'b0;
               w_count_nxt = r_count + CNT_ONE;
            end else begin
               w_count_nxt = r_count - CNT_ONE;
               w_update    = (r_count == CNT_ONE);
            end
         end
         default: begin
            w_dir_nxt = 1'b0;
            if (r_count == r_load_sh) begin
               w_count_nxt = '0;
               w_update    = 1'b1;
            end else begin
               w_count_nxt = r_count + CNT_ONE;
            end
         end
      endcase
   end

   always_comb begin
      w_match_nxt = '0;
      for (int i = 0; i < NCH; i++) begin
         w_match_nxt[i] = (w_count_nxt == cmp[i*WIDTH +: WIDTH]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_psc_cnt <= '0;
         r_load_sh <= '0;
         r_count   <= '0;
         r_dir     <= 1'b0;
         r_running <= 1'b1;
         r_tick    <= 1'b0;
         r_match   <= '0;
      end else if (restart) begin
         r_psc_cnt <= '0;
         r_load_sh <= load;
         r_count   <= (w_mode == MODE_DOWN) ? load : '0;
         r_dir     <= (w_mode == MODE_DOWN);
         r_running <= 1'b1;
         r_tick    <= 1'b0;
         r_match   <= '0;
      end else begin
         r_tick  <= 1'b0;
         r_match <= '0;
         if (w_step) begin
            r_psc_cnt <= '0;
            r_count   <= w_count_nxt;
            r_dir     <= w_dir_nxt;
            r_match   <= w_match_nxt;
            if (w_update) begin
               r_tick    <= 1'b1;
               r_load_sh <= load;
               if (one_shot) r_running <= 1'b0;
            end
         end else if (en && r_running) begin
            r_psc_cnt <= r_psc_cnt + PSC_ONE;
         end
      end
   end

   // Flags follow the registered pulses, so a set in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (rst) r_irq <= '0;
      else     r_irq <= (r_irq & ~irq_clr) | {r_match, r_tick};
   end

`ifdef TIMER_PWM_EN
   logic [NCH-1:0] r_pwm;
   logic [NCH-1:0] w_pwm_nxt;

   always_comb begin
      w_pwm_nxt = '0;
      for (int i = 0; i < NCH; i++) begin
         w_pwm_nxt[i] = (w_count_nxt < cmp[i*WIDTH +: WIDTH]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || restart) r_pwm <= '0;
      else if (w_step)    r_pwm <= w_pwm_nxt;
   end

   assign pwm = r_pwm;
`else
   assign pwm = '0;
`endif

   assign count   = r_count;
   assign dir     = r_dir;
   assign running = r_running;
   assign tick    = r_tick;
   assign match   = r_match;
   assign irq     = r_irq;

endmodule

// File: tb/tb_timer_multi.sv
// Directed self-checking bench for timer_multi: up with load change and irq clear,
// one-shot down, center-aligned, and synchronous reset mid-count.
module tb_timer_multi;

   localparam int WIDTH     = 32;
   localparam int PSC_WIDTH = 16;
   localparam int NCH       = 4;
   localparam logic [WIDTH-1:0] NEVER = '1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic                 restart;
   logic [PSC_WIDTH-1:0] prescaler;
   logic [WIDTH-1:0]     load;
   logic [1:0]           mode;
   logic                 one_shot;
   logic [NCH*WIDTH-1:0] cmp;
   logic [NCH:0]         irq_clr;
   logic [WIDTH-1:0]     count;
   logic                 dir;
   logic                 running;
   logic                 tick;
   logic [NCH-1:0]       match;
   logic [NCH:0]         irq;
   logic [NCH-1:0]       pwm;

   int checks   = 0;
   int failures = 0;

   timer_multi #(.WIDTH(WIDTH), .PSC_WIDTH(PSC_WIDTH), .NCH(NCH)) dut (
      .clk(clk), .rst(rst), .en(en), .restart(restart), .prescaler(prescaler),
      .load(load), .mode(mode), .one_shot(one_shot), .cmp(cmp), .irq_clr(irq_clr),
      .count(count), .dir(dir), .running(running), .tick(tick), .match(match),
      .irq(irq), .pwm(pwm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic pwm_exp(input logic b);
`ifdef TIMER_PWM_EN
      return b;
`else
      return 1'b0 & b;
`endif
   endfunction

   function automatic logic [NCH*WIDTH-1:0] cmp_one(input int ch, input logic [WIDTH-1:0] v);
      logic [NCH*WIDTH-1:0] c;
      c = {NCH{NEVER}};
      c[ch*WIDTH +: WIDTH] = v;
      return c;
   endfunction

   // Up mode, load 4 then 2 from edge 7, cmp0=2; irq clears driven on edges 12, 14, 15.
   int up_cnt  [15] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 0, 1, 2};
   int up_tick [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
   int up_mat  [15] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
   int up_irq  [15] = '{0, 0, 2, 2, 2, 3, 3, 3, 3, 3, 3, 0, 2, 3, 2};
   int up_pwm  [15] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0};
   int up_clr  [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 0, 1, 1};

   // Center mode, load 3, cmp1=2.
   int ce_cnt  [7] = '{1, 2, 3, 2, 1, 0, 1};
   int ce_dir  [7] = '{0, 0, 0, 1, 1, 1, 0};
   int ce_tick [7] = '{0, 0, 0, 0, 0, 1, 0};
   int ce_mat  [7] = '{0, 2, 0, 2, 0, 0, 0};
   int ce_pwm  [7] = '{1, 0, 0, 0, 1, 1, 1};

   initial begin
      rst = 1'b1; en = 1'b0; restart = 1'b0; prescaler = '0; load = '0;
      mode = 2'b00; one_shot = 1'b0; cmp = {NCH{NEVER}}; irq_clr = '0;

      cyc();
      check("rst_count",   64'(count),   64'd0);
      check("rst_dir",     64'(dir),     64'd0);
      check("rst_running", 64'(running), 64'd1);
      check("rst_tick",    64'(tick),    64'd0);
      check("rst_match",   64'(match),   64'd0);
      check("rst_irq",     64'(irq),     64'd0);
      check("rst_pwm",     64'(pwm),     64'd0);

      // ---- up mode ----
      rst = 1'b0; en = 1'b1; mode = 2'b00; prescaler = '0; load = 32'd4;
      cmp = cmp_one(0, 32'd2); restart = 1'b1;
      cyc();
      restart = 1'b0;
      check("up_restart_count", 64'(count), 64'd0);
      check("up_restart_dir",   64'(dir),   64'd0);
      for (int i = 0; i < 15; i++) begin
         irq_clr = (NCH+1)'(up_clr[i]);
         load    = (i >= 6) ? 32'd2 : 32'd4;
         cyc();
         check($sformatf("up_count[%0d]", i), 64'(count), 64'(up_cnt[i]));
         check($sformatf("up_tick[%0d]", i),  64'(tick),  64'(up_tick[i]));
         check($sformatf("up_match[%0d]", i), 64'(match), 64'(up_mat[i]));
         check($sformatf("up_irq[%0d]", i),   64'(irq),   64'(up_irq[i]));
         check($sformatf("up_pwm0[%0d]", i),  64'(pwm[0]), 64'(pwm_exp(up_pwm[i] != 0)));
      end

      // ---- one-shot down, P=2, reload value matches cmp2 ----
      irq_clr = '1; mode = 2'b01; prescaler = 16'd2; load = 32'd3; one_shot = 1'b1;
      cmp = cmp_one(2, 32'd3); restart = 1'b1;
      cyc();
      restart = 1'b0;
      check("dn_restart_count",   64'(count),   64'd3);
      check("dn_restart_dir",     64'(dir),     64'd1);
      check("dn_restart_running", 64'(running), 64'd1);
      for (int c = 1; c <= 15; c++) begin
         if (c == 3) irq_clr = '0;
         cyc();
         check($sformatf("dn_count[%0d]", c),
               64'(count), (c < 3) ? 64'd3 : (c < 6) ? 64'd2 : (c < 9) ? 64'd1 : (c < 12) ? 64'd0 : 64'd3);
         check($sformatf("dn_tick[%0d]", c),    64'(tick),    (c == 12) ? 64'd1 : 64'd0);
         check($sformatf("dn_match[%0d]", c),   64'(match),   (c == 12) ? 64'd4 : 64'd0);
         check($sformatf("dn_running[%0d]", c), 64'(running), (c < 12) ? 64'd1 : 64'd0);
         check($sformatf("dn_dir[%0d]", c),     64'(dir),     64'd1);
         if (c == 1)  check("dn_irq_cleared", 64'(irq), 64'd0);
         if (c == 13) check("dn_irq_set",     64'(irq), 64'd9);
      end

      // ---- center mode ----
      one_shot = 1'b0; mode = 2'b10; prescaler = '0; load = 32'd3;
      cmp = cmp_one(1, 32'd2); restart = 1'b1;
      cyc();
      restart = 1'b0;
      check("ce_restart_count", 64'(count), 64'd0);
      check("ce_restart_dir",   64'(dir),   64'd0);
      check("ce_restart_pwm",   64'(pwm),   64'd0);
      for (int i = 0; i < 7; i++) begin
         cyc();
         check($sformatf("ce_count[%0d]", i), 64'(count),  64'(ce_cnt[i]));
         check($sformatf("ce_dir[%0d]", i),   64'(dir),    64'(ce_dir[i]));
         check($sformatf("ce_tick[%0d]", i),  64'(tick),   64'(ce_tick[i]));
         check($sformatf("ce_match[%0d]", i), 64'(match),  64'(ce_mat[i]));
         check($sformatf("ce_pwm1[%0d]", i),  64'(pwm[1]), 64'(pwm_exp(ce_pwm[i] != 0)));
      end

      // ---- synchronous reset mid-count (count=7, psc_cnt=5) ----
      mode = 2'b00; prescaler = 16'd9; load = 32'd20; cmp = {NCH{NEVER}}; restart = 1'b1;
      cyc();
      restart = 1'b0;
      repeat (75) cyc();
      check("mid_count", 64'(count), 64'd7);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("mid_rst_count",   64'(count),   64'd0);
      check("mid_rst_dir",     64'(dir),     64'd0);
      check("mid_rst_running", 64'(running), 64'd1);
      check("mid_rst_tick",    64'(tick),    64'd0);
      check("mid_rst_match",   64'(match),   64'd0);
      check("mid_rst_irq",     64'(irq),     64'd0);
      check("mid_rst_pwm",     64'(pwm),     64'd0);
      repeat (9) cyc();
      check("post_rst_tick_early", 64'(tick),  64'd0);
      check("post_rst_count_9",    64'(count), 64'd0);
      cyc();
      check("post_rst_tick",       64'(tick),  64'd1);
      check("post_rst_count_10",   64'(count), 64'd0);
      repeat (10) cyc();
      check("post_rst_count_20",   64'(count), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
